// File: rtl/vn_pool_arbiter_pkg.sv
// Shared types and defaults for the entropy-pool controller.
package vn_pool_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FAIL = 2'd2
  } pool_state_e;

  localparam int unsigned NUM_CONS      = 2;
  localparam int unsigned DEF_WORD_W    = 8;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_REP_LIMIT = 16;

endpackage

// File: rtl/vn_pool_fifo.sv
// Synchronous word FIFO; a push is allowed when full if a pop occurs the same cycle.
module vn_pool_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vn_pool_arbiter.sv
// Entropy-pool controller: sequences the unbiaser, packs bits into words,
// runs a repetition-count health test and round-robins words to two consumers.
module vn_pool_arbiter
  import vn_pool_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic                i_bit,
  output logic                o_vn_rst,
  input  logic [NUM_CONS-1:0] i_req,
  output logic [NUM_CONS-1:0] o_gnt,
  output logic [WORD_W-1:0]   o_data,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_health_fail
);

  localparam int unsigned BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WORD_W - 1);
  localparam logic [7:0]     REP_LIM8 = 8'(REP_LIMIT);

  pool_state_e       state;
  pool_state_e       state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] packed_word;
  logic [BCW-1:0]    bit_cnt;
  logic [7:0]        rep_cnt;
  logic [7:0]        rep_nxt;
  logic              last_bit;
  logic              last_gnt;
  logic              grant_vld;
  logic              gnt_idx;
  logic              accept;
  logic              trip;
  logic              word_done;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  assign o_vn_rst      = (state != ST_FILL);
  assign o_health_fail = (state == ST_FAIL);
  assign o_full        = fifo_full;
  assign o_empty       = fifo_empty;

  // Round-robin pick among current requesters; pops the head when granting.
  always_comb begin
    grant_vld = !fifo_empty && (i_req != '0);
    gnt_idx   = 1'b0;
    case (i_req)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = !last_gnt;
      default: gnt_idx = 1'b0;
    endcase
  end

  // Bit acceptance, run-length update, trip detection and word assembly.
  always_comb begin
    accept = (state == ST_FILL) && i_valid && (!fifo_full || grant_vld);
    if (rep_cnt == '0 || i_bit != last_bit) rep_nxt = 8'd1;
    else if (rep_cnt == 8'hFF)              rep_nxt = rep_cnt;
    else                                    rep_nxt = rep_cnt + 8'd1;
    trip      = accept && (rep_nxt == REP_LIM8);
    word_done = accept && !trip && (bit_cnt == LAST_IDX);
    packed_word          = shreg;
    packed_word[bit_cnt] = i_bit;
  end

  // Next-state logic; a trip outranks a disable in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_enable) state_nxt = ST_FILL;
      ST_FILL: begin
        if (trip)           state_nxt = ST_FAIL;
        else if (!i_enable) state_nxt = ST_IDLE;
      end
      ST_FAIL: if (i_clear) state_nxt = i_enable ? ST_FILL : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Packing and repetition counters; zeroed whenever not staying in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (state != ST_FILL || state_nxt != ST_FILL) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (accept) begin
      rep_cnt  <= rep_nxt;
      last_bit <= i_bit;
      if (word_done) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        shreg   <= packed_word;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Grant pulse, delivered word and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_gnt    <= '0;
      o_data   <= '0;
      last_gnt <= 1'b1;
    end else begin
      o_gnt <= '0;
      if (grant_vld) begin
        o_gnt    <= gnt_idx ? 2'b10 : 2'b01;
        o_data   <= fifo_head;
        last_gnt <= gnt_idx;
      end
    end
  end

  vn_pool_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_done),
    .push_data (packed_word),
    .pop       (grant_vld),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/vn_pool_arbiter.md
Name: vn_pool_arbiter

Overview:
Entropy-pool controller sitting directly downstream of the Von Neumann unbiaser wrapper. It sequences the unbiaser by driving its reset, packs the unbiased bit stream into WORD_W-bit words and buffers them in a small FIFO. It runs a repetition-count health test on the bit stream and shares the pool between two consumers with round-robin arbitration.

Parameters:
WORD_W, 8, bits per output word (>=2)
DEPTH, 4, FIFO depth in words (power of two, >=2)
REP_LIMIT, 16, consecutive identical accepted bits that trip the health test (>=2, <=255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  pool enable; low = idle
i_clear  in  1  clears sticky health failure (single-cycle pulse)
i_valid  in  1  bit valid from unbiaser wrapper
i_bit  in  1  bit from unbiaser wrapper
o_vn_rst  out  1  synchronous active-high reset to unbiaser
i_req  in  2  level requests, consumer 0/1
o_gnt  out  2  one-hot grant pulse, one cycle per word delivered
o_data  out  WORD_W  word delivered with o_gnt
o_full  out  1  FIFO holds DEPTH words
o_empty  out  1  FIFO holds 0 words
o_health_fail  out  1  sticky repetition-test failure

Behaviour:
- Reset (rst_n low, async): state IDLE, o_vn_rst=1, o_gnt=0, o_data=0, o_full=0, o_empty=1, o_health_fail=0, FIFO, bit counter, shift register and repetition counter cleared, RR pointer = "1 last granted" (consumer 0 wins first tie).
- States: IDLE, FILL, FAIL (registered).
  - IDLE: o_vn_rst=1; no bits accepted. Partial word and repetition counter held at 0. FIFO contents retained and still drainable. i_enable=1 -> FILL.
  - FILL: o_vn_rst=0. Bit accepted when i_valid=1 and the FIFO can take a word this cycle (not full, or a pop occurs the same cycle). Otherwise the bit is dropped and counters are unchanged. i_enable=0 -> IDLE (partial word discarded). Repetition trip -> FAIL.
  - FAIL: o_health_fail=1, o_vn_rst=1, partial word discarded, no bits accepted, FIFO drainable. i_clear=1 -> FILL if i_enable else IDLE. o_health_fail drops the same edge.
- Precedence in FILL: trip > disable > normal accept.
- Packing: LSB first; the first accepted bit of a word lands in bit 0. On the WORD_W-th accepted bit, the full word is pushed at that same edge. It is visible to arbitration the next cycle. The bit counter wraps to 0.
- Repetition test: counter = run length of identical accepted bits (the first accepted bit sets it to 1; an equal bit increments; a differing bit resets it to 1). When an accepted bit would bring the count to REP_LIMIT -> FAIL at that edge. That bit is not packed, even if it would complete a word. Counter saturates and is cleared on leaving FAIL/IDLE.
- Arbitration: each cycle with FIFO non-empty (registered count) and i_req!=0, one consumer is chosen.
  - Single requester wins.
  - Both requesting -> the one not granted last.
  - On the next edge o_gnt[k]=1 for one cycle, o_data=head word, head popped, RR pointer=k.
  - o_data holds its value when o_gnt=0.
  - Back-to-back grants are allowed every cycle while words remain.
- Simultaneous push+pop when full: allowed, count unchanged. Push when empty plus a request: the word is granted no earlier than the cycle after push (latency push->gnt = 2 edges).
- o_full/o_empty derived from registered count; pointers wrap modulo DEPTH.
- Requests withdrawn: no grant, FIFO unchanged. A request need not be held after its grant.

Decomposition:
- Shared package: state encoding (IDLE/FILL/FAIL), consumer count constant (2), default WORD_W/DEPTH/REP_LIMIT.
- One sub-module: vn_pool_fifo (synchronous FIFO, push/pop, count, full/empty, same-cycle push+pop when full). Packing, health test, FSM and RR arbiter stay in the top.

Test Plan:
- Reset, then i_enable=1, feed 8 valid bits 1,0,1,1,0,0,1,0 with i_req=01 -> o_vn_rst falls one cycle after enable; o_gnt=01 exactly once with o_data=8'h4D; o_empty returns to 1.
- Fill 4 words (8'hA5,8'h3C,8'h0F,8'hF0) with i_req=00 -> o_full=1; further valid bits are dropped. Then i_req=01 for one cycle -> one grant with 8'hA5; the next 8 bits form word 5, not a merge with the dropped bits.
- Both consumers requesting continuously with 4 words queued -> grants 01,10,01,10 on consecutive cycles carrying the words in FIFO order.
- REP_LIMIT=16: feed 16 consecutive 1s after reset -> o_health_fail=1 on the edge of the 16th bit; the first word 8'hFF is granted and the partial word is discarded. o_vn_rst=1 until i_clear, which returns to FILL with counters at 0.
- Deassert i_enable after 5 bits of a word, re-enable, feed 8 bits of 8'h96 -> the delivered word is exactly 8'h96. An earlier queued word survives the disable.
- Assert rst_n low mid-word while o_gnt is pulsing -> all outputs reach reset values immediately (asynchronously). The next grant after release goes to consumer 0 when both request.
